// File: rtl/core_data_mem_responder.sv
// Data-memory responder for the core load/store port: fixed-latency word array with stall.
// Optional MISALIGN_CHECK_EN rejects misaligned requests instead of forcing alignment.
module core_data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          we_q;
  logic [31:0]   wd_q;
  logic [31:0]   rd_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          size_ok, legal, accept, in_idle;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_off;
  logic [2:0]    acc_size;
  logic          acc_we, load_sample, commit;
  logic [31:0]   word, shifted, load_data, wdata;
  logic [15:0]   half;
  logic [3:0]    be;
  logic          unused_addr;

  assign unused_addr = ^mem_addr_i[31:AW+2];

  // B/H/W for either direction; BU/HU are load-only.
  assign size_ok = (mem_size_i == 3'd0) || (mem_size_i == 3'd1) || (mem_size_i == 3'd2) ||
                   (!mem_we_i && ((mem_size_i == 3'd4) || (mem_size_i == 3'd5)));

`ifdef MISALIGN_CHECK_EN
  logic aligned;
  always_comb begin
    aligned = 1'b1;
    case (mem_size_i)
      3'd1, 3'd5: aligned = ~mem_addr_i[0];
      3'd2:       aligned = (mem_addr_i[1:0] == 2'b00);
      default:    aligned = 1'b1;
    endcase
  end
  assign legal      = size_ok & aligned;
  assign misalign_o = mem_req_i & in_idle & ~legal;
`else
  // Misaligned halves/words are implicitly aligned: lane selection ignores the low offset bits.
  assign legal      = size_ok;
  assign misalign_o = 1'b0;
`endif

  assign in_idle = (state_q == StIdle);
  assign accept  = in_idle & mem_req_i & legal;
  // Once accepted the request was legal; only a dropped req ends the stall early.
  assign stall_o = mem_req_i & ((in_idle & legal) | (state_q == StBusy));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY > 1) ? StBusy : StResp;
        end
      end
      StBusy: begin
        if (!mem_req_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY==1 RESP is entered straight from IDLE, so read from the live request.
  assign acc_idx  = in_idle ? mem_addr_i[AW+1:2] : idx_q;
  assign acc_off  = in_idle ? mem_addr_i[1:0]    : off_q;
  assign acc_size = in_idle ? mem_size_i         : size_q;
  assign acc_we   = in_idle ? mem_we_i           : we_q;

  assign load_sample = (state_d == StResp) && (state_q != StResp) && !acc_we;
  assign word        = mem[acc_idx];
  assign shifted     = word >> {acc_off, 3'b000};
  assign half        = acc_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = word;
    case (acc_size)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{half[15]}}, half};
      3'd4:    load_data = {24'h0, shifted[7:0]};
      3'd5:    load_data = {16'h0, half};
      default: load_data = word;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wdata = wd_q;
    case (size_q)
      3'd0: begin
        be    = 4'b0001 << off_q;
        wdata = {4{wd_q[7:0]}};
      end
      3'd1: begin
        be    = off_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd_q[15:0]}};
      end
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign commit = (state_q == StResp) && we_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q  <= mem_addr_i[AW+1:2];
        off_q  <= mem_addr_i[1:0];
        size_q <= mem_size_i;
        we_q   <= mem_we_i;
        wd_q   <= mem_wd_i;
      end
      if (load_sample) rd_q <= load_data;
    end
  end

  // Array is not reset; a reset clears state_q so no commit can follow.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign mem_rd_o = rd_q;

endmodule

// File: tb/tb_core_data_mem_responder.sv
// Directed bench for core_data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_core_data_mem_responder;

  localparam int unsigned Latency = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_i, mem_we_i;
  logic [2:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wd_i;
  logic [31:0] mem_rd_o;
  logic        stall_o, misalign_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] last_rd = 32'h0;

`ifdef MISALIGN_CHECK_EN
  localparam logic MisExp = 1'b1;
`else
  localparam logic MisExp = 1'b0;
`endif

  core_data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (Latency)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .mem_req_i (mem_req_i),
    .mem_we_i  (mem_we_i),
    .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i),
    .mem_wd_i  (mem_wd_i),
    .mem_rd_o  (mem_rd_o),
    .stall_o   (stall_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd);
    mem_req_i  = 1'b1;
    mem_we_i   = we;
    mem_size_i = size;
    mem_addr_i = addr;
    mem_wd_i   = wd;
  endtask

  // Full access; for loads exp_rd becomes the new held value, stores must leave it alone.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    @(negedge clk);
    drive(we, size, addr, wd);
    #1 check({tag, ".stall0"}, {31'h0, stall_o}, 32'h1);
    for (int c = 1; c < Latency; c++) begin
      @(negedge clk);
      mem_addr_i = 32'hFFFF_FFFC;  // later input changes must not affect the access
      mem_wd_i   = 32'h0;
      #1 check({tag, ".stallN"}, {31'h0, stall_o}, 32'h1);
    end
    @(negedge clk);
    #1 check({tag, ".stall_done"}, {31'h0, stall_o}, 32'h0);
    if (!we) last_rd = exp_rd;
    check({tag, ".rd"}, mem_rd_o, last_rd);
    @(negedge clk);
    mem_req_i = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b0;
    mem_req_i  = 1'b0;
    mem_we_i   = 1'b0;
    mem_size_i = 3'd0;
    mem_addr_i = 32'h0;
    mem_wd_i   = 32'h0;
    #1;
    check("reset.rd", mem_rd_o, 32'h0);
    check("reset.stall", {31'h0, stall_o}, 32'h0);
    check("reset.misalign", {31'h0, misalign_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;

    access("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0);
    access("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF);

    access("sw10b", 1'b1, 3'd2, 32'h10, 32'h11223344, 32'h0);
    access("sb13", 1'b1, 3'd0, 32'h13, 32'hFFFF_FFA5, 32'h0);
    access("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, 32'hA5223344);
    access("lb13", 1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFA5);
    access("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h000000A5);
    access("lb11", 1'b0, 3'd0, 32'h11, 32'h0, 32'h00000033);

    access("sw20", 1'b1, 3'd2, 32'h20, 32'hCAFEBABE, 32'h0);
    access("sh22", 1'b1, 3'd1, 32'h22, 32'h1234_8001, 32'h0);
    access("lh22", 1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF8001);
    access("lhu22", 1'b0, 3'd5, 32'h22, 32'h0, 32'h00008001);
    access("lw20", 1'b0, 3'd2, 32'h20, 32'h0, 32'h8001BABE);
    access("lhu20", 1'b0, 3'd5, 32'h20, 32'h0, 32'h0000BABE);

    access("sw04", 1'b1, 3'd2, 32'h04, 32'h0BADF00D, 32'h0);
`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    drive(1'b0, 3'd2, 32'h06, 32'h0);
    #1 check("lw06.misalign", {31'h0, misalign_o}, 32'h1);
    check("lw06.stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    #1 check("lw06.still_idle", {31'h0, misalign_o}, 32'h1);
    check("lw06.rd", mem_rd_o, last_rd);
    mem_req_i = 1'b0;
`else
    access("lw06", 1'b0, 3'd2, 32'h06, 32'h0, 32'h0BADF00D);
`endif

    // Illegal size: SBU-style store is rejected without touching the array.
    @(negedge clk);
    drive(1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF);
    #1 check("ill.stall", {31'h0, stall_o}, 32'h0);
    check("ill.misalign", {31'h0, misalign_o}, {31'h0, MisExp});
    @(negedge clk);
    #1 check("ill.stall2", {31'h0, stall_o}, 32'h0);
    mem_size_i = 3'd3;
    mem_we_i   = 1'b0;
    #1 check("ill3.stall", {31'h0, stall_o}, 32'h0);
    mem_req_i = 1'b0;
    access("ill.lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hA5223344);

    // Reset during a store's BUSY cycle discards it.
    access("sw40", 1'b1, 3'd2, 32'h40, 32'h12345678, 32'h0);
    @(negedge clk);
    drive(1'b1, 3'd2, 32'h40, 32'h9999_9999);
    @(negedge clk);
    #1 check("rstmid.busy_stall", {31'h0, stall_o}, 32'h1);
    rst_i     = 1'b0;
    mem_req_i = 1'b0;
    #1 check("rstmid.rd", mem_rd_o, 32'h0);
    check("rstmid.stall", {31'h0, stall_o}, 32'h0);
    check("rstmid.misalign", {31'h0, misalign_o}, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    rst_i = 1'b1;
    access("lw40", 1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678);

    // Address wrap above the array.
    access("sw00", 1'b1, 3'd2, 32'h0, 32'h55AA55AA, 32'h0);
    access("lw1000", 1'b0, 3'd2, 32'h1000, 32'h0, 32'h55AA55AA);

    // Abort: req drops in BUSY.
    access("sw50", 1'b1, 3'd2, 32'h50, 32'h00000001, 32'h0);
    @(negedge clk);
    drive(1'b1, 3'd2, 32'h50, 32'hFFFF_FFFF);
    @(negedge clk);
    mem_req_i = 1'b0;
    #1 check("abort.stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    #1 check("abort.rd", mem_rd_o, last_rd);
    @(negedge clk);
    #1 check("abort.idle_stall", {31'h0, stall_o}, 32'h0);
    access("lw50", 1'b0, 3'd2, 32'h50, 32'h0, 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_data_mem_responder.md
# core_data_mem_responder

Data-memory responder on the far side of the processor core's load/store port. Accepts the core's request (`mem_req`/`mem_we`/`mem_size`/`mem_addr`/`mem_wd`), holds the core with `stall` for a fixed number of wait cycles, and returns size-extended read data or commits byte-lane writes into an internal word array. It drives exactly the signals the core consumes as `stall_i` and `mem_rd_i`.

## Interface

- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, ≥ 4.
- `LATENCY`, 2: wait cycles per access, ≥ 1.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `mem_req_i`  in  1  core requests an access this cycle.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_size_i`  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `mem_addr_i`  in  32  byte address.
- `mem_wd_i`  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- `mem_rd_o`  out  32  load data, extended per size.
- `stall_o`  out  1  core must hold PC and request.
- `misalign_o`  out  1  request rejected (only with `MISALIGN_CHECK_EN`).

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE, `mem_req_i`=1 and request legal: latch addr, size, we, wd; load counter with `LATENCY`-1; go BUSY if `LATENCY`>1, else RESP.
- BUSY: counter decrements; at counter==1 the next state is RESP. Read data is sampled from the array into `mem_rd_o` on the edge entering RESP.
- RESP: on the edge leaving RESP, a store commits to the array; the FSM returns to IDLE. No back-to-back acceptance on that edge; the next request is taken in IDLE.
- `stall_o` = `mem_req_i` & (state != RESP) & legal. It is combinational.
- `mem_req_i` drops in BUSY: abort, return to IDLE, no write, `mem_rd_o` unchanged.
- Word index = `mem_addr_i`[log2(DEPTH_WORDS)+1:2]. Higher bits are ignored, so addresses wrap.
- Loads: select the byte or half by addr[1:0]/addr[1]. Sizes 0 and 1 sign-extend; 4 and 5 zero-extend; 2 returns the whole word.
- Stores: size 0 writes one byte lane from `wd`[7:0]; size 1 writes two lanes from `wd`[15:0]; size 2 writes all four lanes.
- Illegal size (3, 6, 7, or 4/5 with `mem_we_i`=1): the request is rejected, same handling as a misaligned request. This applies regardless of the macro.
- `mem_rd_o` holds the last completed load value. Stores do not change it.

## Timing

- Reset values: state IDLE, counter 0, `mem_rd_o`=0, `stall_o`=0 (with req low), `misalign_o`=0. The array is not reset.
- Reset mid-access: the access is discarded, no write occurs, and the FSM is IDLE on release.
- Cycle 0 (request first seen): `stall_o`=1.
- Cycles 1..`LATENCY`-1: `stall_o`=1.
- Cycle `LATENCY`: `stall_o`=0 and `mem_rd_o` is valid. The core advances on the edge ending this cycle, and the store commits on the same edge.
- Total access time is `LATENCY`+1 cycles, including the request cycle.
- The latched request is used internally. Changes on the inputs after cycle 0 do not affect the access, except `mem_req_i` dropping (abort).

## Configuration

- `MISALIGN_CHECK_EN` defined:
  - Misaligned requests are rejected: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - On rejection, in the same cycle: `misalign_o`=1, `stall_o`=0, no state change, no write, `mem_rd_o` unchanged.
- `MISALIGN_CHECK_EN` undefined:
  - Low address bits are forced to alignment: addr[0] is cleared for halves, addr[1:0] are cleared for words.
  - `misalign_o` is tied to 0.
  - Illegal sizes are still rejected, but silently.

## Test plan

- `LATENCY`=2: SW 0x10 ← 0xDEADBEEF, then LW 0x10 → `stall_o` is 1 for 2 cycles, then 0 with `mem_rd_o`=0xDEADBEEF.
- Word 0x10 = 0x11223344, then SB 0x13 ← 0xA5:
  - LW 0x10 → 0xA5223344.
  - LB 0x13 → 0xFFFFFFA5.
  - LBU 0x13 → 0x000000A5.
- SH 0x22 ← 0x8001:
  - LH 0x22 → 0xFFFF8001.
  - LHU 0x22 → 0x00008001.
  - Low half of word 0x20 is unchanged.
- LW 0x06:
  - With macro: `misalign_o`=1 and `stall_o`=0 for one cycle; no access occurs.
  - Without macro: returns the word at 0x04 after the normal latency.
- SW 0x40 ← 0x12345678, `rst_i` pulsed low in BUSY → outputs return to reset values; a subsequent LW 0x40 returns the prior contents.
- `DEPTH_WORDS`=1024: LW 0x1000 returns the word at 0x0. Dropping `mem_req_i` mid-SW leaves the target word unchanged.
